exec_unit_mc: RTL and testbench

Parametrised, registered execute stage with multi-cycle multiply/divide. Sits between DECODE and MEMORY and replaces the combinational execute stage. It keeps the 12 single-cycle ALU operations, the ALUSrc/RegDst muxes and the zero/overflow flags, widened to WIDTH bits. It adds iterative unsigned MULTU/DIVU into internal HI/LO registers, plus MFHI/MFLO, behind valid/ready handshakes on both sides.

---
 rtl/exec_unit_mc_if.sv | 17 +
 rtl/exec_unit_mc.sv | 99 +++++++++
 tb/tb_exec_unit_mc.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_mc_if.sv
// exec_unit_mc_if: DECODE-side and MEMORY-side valid/ready bus of the execute stage
interface exec_unit_mc_if #(parameter int WIDTH = 32);
  localparam int SHW = $clog2(WIDTH);
  logic in_valid, in_ready, ALUSrc, RegDst, out_valid, out_ready, zeroflag, overFlow;
  logic [WIDTH-1:0] Operand1, Operand2, ImmediateField, ALUresult;
  logic [3:0] ALUOp;
  logic [SHW-1:0] shamt;
  logic [4:0] rd, rt, WriteReg;
  modport master(
    output in_valid, Operand1, Operand2, ImmediateField, ALUSrc, ALUOp, shamt, rd, rt, RegDst, out_ready,
    input in_ready, out_valid, ALUresult, zeroflag, overFlow, WriteReg
  );
  modport slave(
    input in_valid, Operand1, Operand2, ImmediateField, ALUSrc, ALUOp, shamt, rd, rt, RegDst, out_ready,
    output in_ready, out_valid, ALUresult, zeroflag, overFlow, WriteReg
  );
endinterface

// File: rtl/exec_unit_mc.sv
// exec_unit_mc: registered execute stage with iterative MULTU/DIVU into HI/LO
module exec_unit_mc #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic clk,
  input logic rst_n,
  exec_unit_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] a, b, res, hi, lo, m;
  logic [2*WIDTH-1:0] work, work_n;
  logic [WIDTH:0] sum, r, d;
  logic [SHW-1:0] cnt;
  logic [4:0] wr, pw;
  logic accept, done, multi, ovf, pz;
  assign a = bus.Operand1;
  assign b = bus.ALUSrc ? bus.ImmediateField : bus.Operand2;
  assign wr = bus.RegDst ? bus.rd : bus.rt;
  assign multi = bus.ALUOp == 4'd12 || bus.ALUOp == 4'd13;
  assign bus.in_ready = state == IDLE && (!bus.out_valid || bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign done = state != IDLE && cnt == SHW'(WIDTH - 1);
  // MUL: work = {partial product, remaining multiplier}; DIV: work = {remainder, dividend/quotient}
  assign sum = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, work[0] ? m : '0};
  assign r = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
  assign d = r - {1'b0, m};
  assign work_n = state == MUL ? {sum, work[WIDTH-1:1]}
                               : {d[WIDTH] ? r[WIDTH-1:0] : d[WIDTH-1:0], work[WIDTH-2:0], !d[WIDTH]};
  always_comb begin
    res = '0;
    case (bus.ALUOp)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = b << bus.shamt;
      4'd5: res = b >> bus.shamt;
      4'd6: res = $signed(b) >>> bus.shamt;
      4'd7: res = WIDTH'($signed(a) > $signed(b));
      4'd8: res = WIDTH'($signed(a) < $signed(b));
      4'd9: res = b << (WIDTH / 2);
      4'd10: res = ~(a | b);
      4'd11: res = a ^ b;
      4'd14: res = hi;
      4'd15: res = lo;
      default: res = '0;
    endcase
    ovf = (bus.ALUOp == 4'd0 && a[WIDTH-1] == b[WIDTH-1] && res[WIDTH-1] != a[WIDTH-1]) ||
          (bus.ALUOp == 4'd1 && a[WIDTH-1] != b[WIDTH-1] && res[WIDTH-1] != a[WIDTH-1]);
    state_n = done ? IDLE : (accept && bus.ALUOp == 4'd12) ? MUL : (accept && bus.ALUOp == 4'd13) ? DIV : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      work <= '0;
      m <= '0;
      pz <= 1'b0;
      pw <= '0;
      hi <= '0;
      lo <= '0;
      bus.out_valid <= 1'b0;
      bus.ALUresult <= '0;
      bus.zeroflag <= 1'b0;
      bus.overFlow <= 1'b0;
      bus.WriteReg <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        m <= bus.ALUOp == 4'd12 ? a : b;
        work <= {{WIDTH{1'b0}}, bus.ALUOp == 4'd12 ? b : a};
        cnt <= '0;
        pz <= a == b;
        pw <= wr;
      end else if (state != IDLE) begin
        work <= work_n;
        cnt <= cnt + 1'b1;
      end
      if (done) {hi, lo} <= work_n;
      if (accept && !multi) begin
        bus.out_valid <= 1'b1;
        bus.ALUresult <= res;
        bus.zeroflag <= a == b;
        bus.overFlow <= ovf;
        bus.WriteReg <= wr;
      end else if (done) begin
        bus.out_valid <= 1'b1;
        bus.ALUresult <= work_n[WIDTH-1:0];
        bus.zeroflag <= pz;
        bus.overFlow <= 1'b0;
        bus.WriteReg <= pw;
      end else if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_exec_unit_mc.sv
// tb_exec_unit_mc: directed and random stimulus against a queue-based arithmetic model
module tb_exec_unit_mc;
  localparam int W = 32;
  typedef struct {logic [W-1:0] res; logic z, ov; logic [4:0] wr;} exp_t;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  exec_unit_mc_if #(.WIDTH(W)) bus();
  exec_unit_mc #(.WIDTH(W)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  exp_t q[$];
  logic [W-1:0] mhi = '0, mlo = '0, h_res;
  logic [4:0] h_wr;
  bit accepted, prev_hold;
  int vectors = 0, miscompares = 0, cyc, lows;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push_model();
    logic [W-1:0] a, b, r;
    logic [2*W-1:0] p;
    longint s;
    exp_t e;
    a = bus.Operand1;
    b = bus.ALUSrc ? bus.ImmediateField : bus.Operand2;
    r = '0;
    s = 0;
    case (bus.ALUOp)
      0: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b)); end
      1: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b)); end
      2: r = a & b;
      3: r = a | b;
      4: r = b << bus.shamt;
      5: r = b >> bus.shamt;
      6: r = W'($signed(b) >>> bus.shamt);
      7: r = ($signed(a) > $signed(b)) ? 1 : 0;
      8: r = ($signed(a) < $signed(b)) ? 1 : 0;
      9: r = b * 32'h10000;
      10: r = ~(a | b);
      11: r = a ^ b;
      12: begin p = {{W{1'b0}}, a} * {{W{1'b0}}, b}; mhi = p[2*W-1:W]; mlo = p[W-1:0]; r = mlo; end
      13: begin
        if (b == 0) begin mlo = '1; mhi = a; end
        else begin mlo = a / b; mhi = a % b; end
        r = mlo;
      end
      14: r = mhi;
      default: r = mlo;
    endcase
    e.res = r;
    e.z = a == b;
    e.ov = (bus.ALUOp <= 1) && (s != longint'($signed(r)));
    e.wr = bus.RegDst ? bus.rd : bus.rt;
    q.push_back(e);
  endtask
  task automatic tick();
    exp_t e;
    #1;
    accepted = bus.in_valid && bus.in_ready;
    if (prev_hold) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_res", bus.ALUresult, h_res);
      check("hold_wreg", bus.WriteReg, h_wr);
    end
    if (accepted) push_model();
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        check("res", bus.ALUresult, e.res);
        check("zero", bus.zeroflag, e.z);
        check("ovf", bus.overFlow, e.ov);
        check("wreg", bus.WriteReg, e.wr);
      end
    end
    prev_hold = bus.out_valid && !bus.out_ready;
    h_res = bus.ALUresult;
    h_wr = bus.WriteReg;
    @(negedge clk);
  endtask
  task automatic set_op(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] imm, logic src, logic [4:0] sh, logic rdst);
    bus.ALUOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.ImmediateField = imm;
    bus.ALUSrc = src;
    bus.shamt = sh;
    bus.RegDst = rdst;
    bus.rd = 5;
    bus.rt = 9;
    bus.in_valid = 1;
  endtask
  task automatic issue(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b, logic [W-1:0] imm, logic src, logic [4:0] sh, logic rdst);
    set_op(op, a, b, imm, src, sh, rdst);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (accepted) break;
    end
    if (!accepted) check("accept_timeout", 0, 1);
    bus.in_valid = 0;
  endtask
  task automatic wait_out();
    cyc = 0;
    lows = 0;
    while (!bus.out_valid && cyc < 100) begin
      if (!bus.in_ready) lows++;
      tick();
      cyc++;
    end
  endtask
  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      4: return W'($urandom_range(0, 9));
      default: return W'($urandom);
    endcase
  endfunction
  initial begin
    logic [3:0] op;
    bus.in_valid = 0;
    bus.out_ready = 1;
    set_op(0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_res", bus.ALUresult, 0);
    check("rst_flags", {bus.zeroflag, bus.overFlow}, 0);
    check("rst_wreg", bus.WriteReg, 0);
    rst_n = 1;
    #1 check("rst_inready", bus.in_ready, 1);
    @(negedge clk);
    issue(0, 32'h7FFFFFFF, 1, 0, 0, 0, 1);
    check("add_lat1", bus.out_valid, 1);
    check("add_res", bus.ALUresult, 32'h80000000);
    check("add_ovf", bus.overFlow, 1);
    check("add_zero", bus.zeroflag, 0);
    issue(6, 0, 0, 32'hF0000000, 1, 4, 1);
    check("sra_res", bus.ALUresult, 32'hFF000000);
    check("sra_wreg_rd", bus.WriteReg, 5);
    issue(9, 0, 32'h1234, 0, 0, 0, 0);
    check("lui_res", bus.ALUresult, 32'h12340000);
    check("lui_wreg_rt", bus.WriteReg, 9);
    issue(12, '1, '1, 0, 0, 0, 1);
    wait_out();
    check("mul_latency", cyc, W);
    check("mul_inready_low", lows, W);
    check("mul_lo", bus.ALUresult, 1);
    issue(14, 0, 0, 0, 0, 0, 1);
    check("mfhi_mul", bus.ALUresult, 32'hFFFFFFFE);
    issue(15, 0, 0, 0, 0, 0, 1);
    check("mflo_mul", bus.ALUresult, 1);
    issue(13, 100, 7, 0, 0, 0, 0);
    wait_out();
    check("div_latency", cyc, W);
    check("div_lo", bus.ALUresult, 14);
    issue(14, 0, 0, 0, 0, 0, 0);
    check("mfhi_div", bus.ALUresult, 2);
    issue(13, 5, 0, 0, 0, 0, 0);
    wait_out();
    check("div0_lo", bus.ALUresult, 32'hFFFFFFFF);
    issue(14, 0, 0, 0, 0, 0, 0);
    check("mfhi_div0", bus.ALUresult, 5);
    issue(0, 3, 4, 0, 0, 0, 1);
    bus.out_ready = 0;
    set_op(1, 10, 3, 0, 0, 0, 0);
    repeat (3) begin
      tick();
      check("stall_no_accept", accepted, 0);
    end
    bus.out_ready = 1;
    #1 check("drain_inready", bus.in_ready, 1);
    tick();
    check("drain_accept", accepted, 1);
    bus.in_valid = 0;
    tick();
    issue(12, W'($urandom), W'($urandom), 0, 0, 0, 1);
    repeat (10) tick();
    rst_n = 0;
    #1;
    check("abort_valid", bus.out_valid, 0);
    check("abort_outs", {bus.ALUresult, bus.zeroflag, bus.overFlow, bus.WriteReg}, 0);
    q.delete();
    mhi = '0;
    mlo = '0;
    prev_hold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 check("abort_inready", bus.in_ready, 1);
    @(negedge clk);
    lows = 0;
    repeat (40) begin
      if (bus.out_valid) lows++;
      tick();
    end
    check("abort_no_commit", lows, 0);
    issue(15, 0, 0, 0, 0, 0, 1);
    check("abort_mflo", bus.ALUresult, 0);
    for (int i = 0; i < 1500; i++) begin
      op = 4'($urandom_range(0, 15));
      if ((op == 12 || op == 13) && $urandom_range(0, 3) != 0) op = 4'($urandom_range(0, 11));
      set_op(op, rnd(), rnd(), rnd(), 1'($urandom), 5'($urandom), 1'($urandom));
      bus.rd = 5'($urandom);
      bus.rt = 5'($urandom);
      bus.in_valid = $urandom_range(0, 9) < 7;
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 100 && (q.size() != 0 || bus.out_valid); i++) tick();
    check("drain_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
